fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch buffer between the PC/instruction-memory fetch stage and the decode stage of the pipelined MIPS core. Each cycle it captures the fetched {PC, instruction} pair into a small FIFO and presents the oldest entry to decode. It decouples fetch from decode stalls: its `in_ready` drives the PC register's `stall` input as `stall = ~in_ready`. A `flush` from a taken branch or jump redirect discards everything buffered.

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the fetch stage presents a valid pair this cycle.
- `in_pc`  in  32  PC of the fetched instruction.
- `in_instr`  in  32  instruction word read from instruction memory.
- `in_ready`  out  1  the buffer can accept a push this cycle.
- `flush`  in  1  discard all entries, including any push in the same cycle.
- `out_valid`  out  1  the head entry is valid.
- `out_pc`  out  32  PC of the head entry.
- `out_instr`  out  32  instruction of the head entry.
- `out_ready`  in  1  decode consumes the head this cycle (`~stall_D`).
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: `DEPTH`-entry circular array with read pointer `rp`, write pointer `wp` and occupancy counter `count`. Pointers are $clog2(DEPTH) bits wide and wrap modulo `DEPTH`.
- `in_ready = (count != DEPTH)`. It is combinational from registered state only and never depends on `out_ready`, so a full buffer rejects a push even when a pop happens in the same cycle.
- Push: `in_valid & in_ready & ~flush`. The pair is written at `wp`, then `wp` increments.
- Pop: `out_valid & out_ready & ~flush`. Then `rp` increments.
- Count update: push only gives +1; pop only gives −1; push and pop together leave `count` unchanged.
- `out_valid = (count != 0)`. When `out_valid` is 0, `out_pc` and `out_instr` are driven to `32'h0`, so decode sees a nop (sll $0,$0,0).
- Flush has priority over push and pop. On the next edge `rp`, `wp` and `count` go to 0. Array contents need not be cleared.
- Reset: `rp = wp = count = 0`. After reset, `out_valid = 0`, `out_pc = out_instr = 0` and `in_ready = 1`.
- Reset mid-operation discards all entries exactly as flush does. Reset has priority over flush.
- Ordering is strictly FIFO; no entry is ever reordered or duplicated.

## Timing
- Latency from push to head is 1 cycle when the buffer is empty (no bypass, unless configured as below). An entry pushed at edge N is visible on `out_*` after edge N.
- Throughput is one push and one pop per cycle sustained whenever 0 < `count` < `DEPTH`.
- Full case: with `count == DEPTH`, `in_ready` is low for the whole cycle and the PC holds. A pop that cycle sets `count = DEPTH-1`, and `in_ready` rises in the next cycle.
- Empty case: with `count == 0`, `out_ready` is ignored and no pop occurs.
- Flush in cycle N makes `out_valid` 0 and `in_ready` 1 in cycle N+1. The first post-redirect push is accepted in cycle N+1.

## Configuration
- Macro: `FETCH_BUF_BYPASS_EN`.
- When defined, with `count == 0`: `out_valid = in_valid & ~flush`, and `out_pc`/`out_instr` = `in_pc`/`in_instr` combinationally.
  - If `out_ready` is also 1, the pair passes straight through and is not stored: no push, `count` stays 0.
  - If `out_ready` is 0, the pair is pushed normally.
  - This gives zero-cycle fetch-to-decode latency when empty. When `count > 0` the behaviour is identical to the non-bypass build.
- When undefined, empty-buffer latency is 1 cycle as specified above.

## Test plan
- Reset: assert `reset` for 2 cycles while `in_valid = 1`. Required: `count = 0`, `out_valid = 0`, `out_pc = out_instr = 0`, `in_ready = 1`.
- Fill to full (`DEPTH = 4`): push PCs 0x3000, 0x3004, 0x3008, 0x300C with `out_ready = 0`.
  - Required: `count = 4` and `in_ready = 0`.
  - A 5th push (0x3010) is ignored.
  - Then with `out_ready = 1`, pops return 0x3000, 0x3004, 0x3008, 0x300C in order.
- Full with simultaneous pop: at `count = 4`, drive `in_valid = 1` and `out_ready = 1`. Required: the pop occurs, the push is rejected, `count = 3`, and `in_ready = 1` in the next cycle.
- Flush: at `count = 3`, assert `flush` with `in_valid = 1` (PC 0x4000). Required next cycle: `count = 0` and `out_valid = 0`. A push of 0x4000 one cycle later appears at the head one cycle after that.
- Wrap-around: stream 10 entries (PC 0x3000 + 4i) with `out_ready` toggling 1,0,1,1,0, repeating. Required: the output sequence is exactly 0x3000 through 0x3024 with no loss or duplication, and `count` never exceeds 4.
- Bypass (`FETCH_BUF_BYPASS_EN` defined), empty buffer, `in_valid = out_ready = 1` with PC 0x3000:
  - Required: `out_valid = 1` and `out_pc = 0x3000` in the same cycle, with `count` remaining 0.
  - Without the macro: `out_valid = 0` that cycle and `out_pc = 0x3000` in the next cycle.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch buffer between the fetch stage and decode.
// Holds {PC, instruction} pairs in a DEPTH-entry circular FIFO and presents
// the oldest pair to decode. in_ready drives the PC stall (stall = ~in_ready).
// A flush from a taken branch/jump redirect discards every buffered entry.
// Optional feature: define FETCH_BUF_BYPASS_EN to let a fetched pair pass
// straight to decode in the same cycle when the buffer is empty.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic          empty;
  logic          push;
  logic          pop;

  // Ready depends only on registered occupancy, so a full buffer rejects a
  // push even if decode pops in the same cycle.
  assign empty    = (count == '0);
  assign in_ready = (count != FULL_COUNT);

  // Popping only ever removes a stored entry; an empty buffer ignores out_ready.
  assign pop = ~empty & out_ready & ~flush;

`ifdef FETCH_BUF_BYPASS_EN
  // A pair arriving at an empty buffer is shown to decode immediately. Reset
  // holds decode on a nop, so the bypass is suppressed while it is asserted.
  logic bypass_valid;
  assign bypass_valid = empty & in_valid & ~flush & ~reset;
  assign out_valid    = empty ? bypass_valid : 1'b1;
  // If decode takes the bypassed pair right away it is never stored.
  assign push = in_valid & in_ready & ~flush & ~(bypass_valid & out_ready);
`else
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
`endif

  // Head selection: stored head when occupied, bypassed pair if enabled,
  // otherwise all zeros so decode sees a nop (sll $0,$0,0).
  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (!empty) begin
      out_pc    = pc_mem[rp];
      out_instr = instr_mem[rp];
    end
`ifdef FETCH_BUF_BYPASS_EN
    else if (bypass_valid) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
  end

  // Storage array write; contents are left untouched by reset and flush since
  // occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp]    <= in_pc;
      instr_mem[wp] <= in_instr;
    end
  end

  // Pointer and occupancy update; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: self-checking bench for fetch_buffer (DEPTH = 4).
// Directed table of vectors, a wrap-around streaming sequence, and a
// randomized phase checked against a queue-based reference model.
// Expectations follow the FETCH_BUF_BYPASS_EN setting of the build.
module tb_fetch_buffer;

  localparam int DEPTH = 4;

`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int checks;
  int failures;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          chk;
    bit          rst;
    bit          v;
    logic [31:0] pc;
    bit          fl;
    bit          ordy;
    int          cnt;
    bit          irdy;
    bit          oval;
    logic [31:0] opc;
  } vec_t;

  vec_t vecs[$];

  // Instruction word tied to its PC so the instruction path is checked too.
  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'h8C21_5A5A;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] pc,
                               input logic [31:0] instr, input bit f, input bit o);
    reset     = r;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    flush     = f;
    out_ready = o;
  endtask

  task automatic checkOutput(input string tag, input int ecnt, input bit eirdy,
                             input bit eval, input logic [31:0] epc, input logic [31:0] einstr);
    cmp({tag, " count"},     32'(count),     32'(ecnt));
    cmp({tag, " in_ready"},  32'(in_ready),  32'(eirdy));
    cmp({tag, " out_valid"}, 32'(out_valid), 32'(eval));
    cmp({tag, " out_pc"},    out_pc,         epc);
    cmp({tag, " out_instr"}, out_instr,      einstr);
  endtask

  task automatic addRow(input bit chk, input bit rst, input bit v, input logic [31:0] pc,
                        input bit fl, input bit ordy, input int cnt, input bit irdy,
                        input bit oval, input logic [31:0] opc);
    vec_t row;
    row.chk = chk; row.rst = rst; row.v = v; row.pc = pc; row.fl = fl; row.ordy = ordy;
    row.cnt = cnt; row.irdy = irdy; row.oval = oval; row.opc = opc;
    vecs.push_back(row);
  endtask

  initial begin
    bit          rdy_pat [5];
    logic [31:0] got[$];
    logic [63:0] mq[$];
    int          sent;
    int          cyc;

    checks   = 0;
    failures = 0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Directed table: each row's outputs are checked just before its edge.
    // Reset two cycles with in_valid high.
    addRow(0, 1, 1, 32'h3000, 0, 0, 0, 1, 0, 32'h0);
    addRow(1, 1, 1, 32'h3000, 0, 0, 0, 1, 0, 32'h0);
    // Fill to full with decode stalled.
    addRow(1, 0, 1, 32'h3000, 0, 0, 0, 1, BYP, BYP ? 32'h3000 : 32'h0);
    addRow(1, 0, 1, 32'h3004, 0, 0, 1, 1, 1, 32'h3000);
    addRow(1, 0, 1, 32'h3008, 0, 0, 2, 1, 1, 32'h3000);
    addRow(1, 0, 1, 32'h300C, 0, 0, 3, 1, 1, 32'h3000);
    // Fifth push rejected while full.
    addRow(1, 0, 1, 32'h3010, 0, 0, 4, 0, 1, 32'h3000);
    // Full with simultaneous pop: pop occurs, push still rejected.
    addRow(1, 0, 1, 32'h3010, 0, 1, 4, 0, 1, 32'h3000);
    // Drain in order; in_ready is back up after the pop.
    addRow(1, 0, 0, 32'h0,    0, 1, 3, 1, 1, 32'h3004);
    addRow(1, 0, 0, 32'h0,    0, 1, 2, 1, 1, 32'h3008);
    addRow(1, 0, 0, 32'h0,    0, 1, 1, 1, 1, 32'h300C);
    // Empty: out_ready ignored.
    addRow(1, 0, 0, 32'h0,    0, 1, 0, 1, 0, 32'h0);
    // Build count = 3, then flush with a push pending.
    addRow(1, 0, 1, 32'h3100, 0, 0, 0, 1, BYP, BYP ? 32'h3100 : 32'h0);
    addRow(1, 0, 1, 32'h3104, 0, 0, 1, 1, 1, 32'h3100);
    addRow(1, 0, 1, 32'h3108, 0, 0, 2, 1, 1, 32'h3100);
    addRow(1, 0, 1, 32'h4000, 1, 1, 3, 1, 1, 32'h3100);
    // First post-redirect push accepted the next cycle, at head one later.
    addRow(1, 0, 1, 32'h4000, 0, 0, 0, 1, BYP, BYP ? 32'h4000 : 32'h0);
    addRow(1, 0, 0, 32'h0,    0, 0, 1, 1, 1, 32'h4000);
    addRow(1, 0, 0, 32'h0,    0, 1, 1, 1, 1, 32'h4000);
    // Empty buffer with in_valid and out_ready: bypass passes through.
    addRow(1, 0, 1, 32'h3000, 0, 1, 0, 1, BYP, BYP ? 32'h3000 : 32'h0);
    addRow(1, 0, 0, 32'h0,    0, 0, BYP ? 0 : 1, 1, !BYP, BYP ? 32'h0 : 32'h3000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].pc, instrOf(vecs[i].pc),
                    vecs[i].fl, vecs[i].ordy);
      #1;
      if (vecs[i].chk) begin
        checkOutput($sformatf("row%0d", i), vecs[i].cnt, vecs[i].irdy, vecs[i].oval,
                    vecs[i].opc, vecs[i].oval ? instrOf(vecs[i].opc) : 32'h0);
      end
    end

    // Wrap-around stream: 10 entries with a 1,0,1,1,0 decode-ready pattern.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sent = 0;
    cyc  = 0;
    while (got.size() < 10 && cyc < 100) begin
      @(negedge clk);
      applyStimulus(1'b0, sent < 10, 32'h3000 + 32'(4 * sent),
                    instrOf(32'h3000 + 32'(4 * sent)), 1'b0, rdy_pat[cyc % 5]);
      #1;
      cmp($sformatf("wrap cyc%0d count<=4", cyc), 32'(count <= 3'd4), 32'd1);
      if (out_valid && out_ready) got.push_back(out_pc);
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    cmp("wrap received entries", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++) begin
      cmp($sformatf("wrap order %0d", i), got[i], 32'h3000 + 32'(4 * i));
    end

    // Randomized phase against a queue model of the FIFO rules.
    for (int c = 0; c < 2000; c++) begin
      bit          r;
      bit          v;
      bit          f;
      bit          o;
      logic [31:0] pc;
      logic [31:0] ins;
      int          n;
      bit          eval;
      logic [31:0] epc;
      logic [31:0] eins;
      bit          pass;

      r   = (c == 0) || ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 11) == 0);
      o   = ($urandom_range(0, 2) != 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      ins = $urandom;

      @(negedge clk);
      applyStimulus(r, v, pc, ins, f, o);
      #1;
      n = mq.size();
      if (c > 0) begin
        eval = 1'b0;
        epc  = 32'h0;
        eins = 32'h0;
        if (n > 0) begin
          eval = 1'b1;
          epc  = mq[0][63:32];
          eins = mq[0][31:0];
        end else if (BYP && v && !f && !r) begin
          eval = 1'b1;
          epc  = pc;
          eins = ins;
        end
        checkOutput($sformatf("rand%0d", c), n, n < DEPTH, eval, epc, eins);
      end

      if (r || f) begin
        mq.delete();
      end else begin
        pass = BYP && (n == 0) && v && o;
        if (n > 0 && o) void'(mq.pop_front());
        if (v && n < DEPTH && !pass) mq.push_back({pc, ins});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
